clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures a slow, asynchronous square wave, such as the output of the board's clock divider or an external slow clock, in units of the fast system clock. Each input edge is also presented to the fast domain as a single-cycle tick. Completed period and high-time measurements are delivered through a valid/ack handshake. The block sits in the fast domain next to the divider and is used for bring-up, self-check of divider ratios, and slow-event timing.

## Interface
- CntWidth, 26: width of the internal counter and of the Period and HighTime outputs.
- TimeoutVal, 50000000: fast cycles without a rising edge before a timeout is declared. Must be at least 2 and no more than 2^CntWidth-1.

- Clk  in  1  fast system clock; everything is on its rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ClkIn  in  1  slow input, asynchronous to Clk.
- Enable  in  1  measurement enable, synchronous, active-high.
- Ack  in  1  consumer accepts the current result.
- RiseTick  out  1  one-cycle pulse per synchronized ClkIn rising edge.
- FallTick  out  1  one-cycle pulse per synchronized ClkIn falling edge.
- Period  out  CntWidth  fast cycles between two consecutive RiseTicks.
- HighTime  out  CntWidth  fast cycles from a RiseTick to the following FallTick.
- Valid  out  1  result available; held high until accepted.
- Overrun  out  1  sticky: a result was dropped because the previous one was not yet accepted.
- Timeout  out  1  sticky: no rising edge within TimeoutVal cycles.

## Operation
- Input path: two-flop synchronizer on ClkIn, plus a third delayed copy for edge detection.
  - RiseTick = s2 & ~s3; FallTick = ~s2 & s3.
  - Ticks are generated whenever the block is out of reset, regardless of Enable.
- State machine: IDLE, ARM, MEAS.
  - IDLE: counter held at 0. If Enable=1, go to ARM.
  - ARM: wait for the first RiseTick. On RiseTick, clear the counter and go to MEAS. No result is produced from ARM.
  - MEAS: counter increments every cycle.
    - On FallTick: HighHold <= cnt+1.
    - On RiseTick: candidate Period = cnt+1, candidate HighTime = HighHold. Clear the counter and stay in MEAS.
  - Enable=0 in any state: go to IDLE next cycle. The counter and HighHold clear; Valid and the result registers are unaffected.
- Timeout: applies in ARM or MEAS. If cnt reaches TimeoutVal-1 with no RiseTick in that cycle:
  - set Timeout=1, clear the counter, go to ARM;
  - the partial measurement is discarded.
- Timeout clear: Timeout clears on the next RiseTick. The set condition has priority if both occur in the same cycle.
- Counter: cannot reach 2^CntWidth because of the timeout.
- Missing fall: if no FallTick occurred since the last RiseTick, the published HighTime is 0.
- Handshake:
  - Publishing: on a candidate result, if Valid=0, or if Valid=1 and Ack=1 in the same cycle, load Period and HighTime and set Valid=1.
  - Dropping: otherwise the candidate is dropped and Overrun is set.
  - Ack: Ack with Valid=1 and no new candidate clears Valid next cycle. Ack with Valid=0 is ignored.
  - Overrun clears only on reset or on an Enable falling transition.
- Reset values: state IDLE; synchronizer flops 0; counter 0; HighHold 0; RiseTick, FallTick, Valid, Overrun and Timeout all 0; Period and HighTime 0.
  - Reset mid-measurement abandons all progress immediately, with no partial result.

## Timing
- ClkIn edge to RiseTick/FallTick: 2-3 Clk cycles, depending on sampling phase.
- Tick width: exactly 1 cycle.
- Minimum resolvable ClkIn high or low time: 2 Clk cycles. Narrower pulses may be missed; this is not an error condition.
- Result timing:
  - A result is visible on Period and HighTime with Valid=1 one cycle after the closing RiseTick.
  - Valid drops one cycle after an accepting Ack.
  - A back-to-back replace (Ack coinciding with a new candidate) keeps Valid high continuously.
- Measurement values: RiseTicks at cycles t and t+N give Period=N. A FallTick at t+H gives HighTime=H.
- Latency: first result after Enable needs two rising edges. Any Enable drop restarts from ARM.

## Test plan
- CntWidth=8, TimeoutVal=200, ClkIn period 20 Clk at 50% duty -> first Valid after the 2nd RiseTick with Period=20 and HighTime=10. Each later result is 20/10 while Ack is returned each time.
- ClkIn period 30, high 7, Ack withheld for three periods -> first result held stable, Overrun=1. After Ack the next result reads 30/7.
- ClkIn stopped low after lock -> Timeout=1 exactly 200 cycles after the last RiseTick, state ARM, no result. Restarting ClkIn clears Timeout on the first RiseTick and produces a new result on the second.
- Ack asserted in the same cycle as a candidate while Valid=1 -> new values loaded, Valid stays 1, Overrun stays 0.
- Enable dropped mid-period -> no result. Previously valid outputs stay held. Re-enable needs two rising edges before the next result.
- Rst pulsed low asynchronously mid-measurement -> all outputs 0 immediately. After release, behaviour is identical to power-up.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous square wave in fast
// Clk cycles, with single-cycle edge ticks and a valid/ack result handshake.
module clk_period_meter #(
  parameter int CntWidth   = 26,
  parameter int TimeoutVal = 50000000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                ClkIn,
  input  logic                Enable,
  input  logic                Ack,
  output logic                RiseTick,
  output logic                FallTick,
  output logic [CntWidth-1:0] Period,
  output logic [CntWidth-1:0] HighTime,
  output logic                Valid,
  output logic                Overrun,
  output logic                Timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS
  } state_t;

  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutVal - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic                r_en_d;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_high_hold;
  logic [CntWidth-1:0] r_period;
  logic [CntWidth-1:0] r_high_time;
  logic                r_valid;
  logic                r_overrun;
  logic                r_timeout;

  logic                w_rise;
  logic                w_fall;
  logic                w_cand;
  logic                w_to_hit;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic [CntWidth-1:0] w_cnt_p1;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ClkIn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise   = r_s2 & ~r_s3;
  assign w_fall   = ~r_s2 & r_s3;
  assign w_cnt_p1 = r_cnt + CntOne;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
      r_en_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= Enable;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand      = 1'b0;
    w_to_hit    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (!Enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_cnt_clr   = 1'b1;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_MEAS;
          end else if (r_cnt == CntLast) begin
            w_to_hit  = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_MEAS: begin
          if (w_rise) begin
            w_cand    = 1'b1;
            w_cnt_clr = 1'b1;
          end else if (r_cnt == CntLast) begin
            w_to_hit    = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_ARM;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  // A rise with no fall since the previous rise must publish HighTime = 0
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt       <= '0;
      r_high_hold <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= w_cnt_p1;
      end
      if (!Enable || w_rise || w_to_hit) begin
        r_high_hold <= '0;
      end else if (r_state == ST_MEAS && w_fall) begin
        r_high_hold <= w_cnt_p1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
    end else if (w_cand && (!r_valid || Ack)) begin
      r_period    <= w_cnt_p1;
      r_high_time <= r_high_hold;
      r_valid     <= 1'b1;
    end else if (!w_cand && r_valid && Ack) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_en_d && !Enable) begin
        r_overrun <= 1'b0;
      end else if (w_cand && r_valid && !Ack) begin
        r_overrun <= 1'b1;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end else if (w_rise) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign RiseTick = w_rise;
  assign FallTick = w_fall;
  assign Period   = r_period;
  assign HighTime = r_high_time;
  assign Valid    = r_valid;
  assign Overrun  = r_overrun;
  assign Timeout  = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: scoreboard of expected Period/HighTime
// pairs, popped whenever the bench accepts a result with Ack.
module tb_clk_period_meter;
  localparam int CW = 8;
  localparam int TO = 200;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          ClkIn;
  logic          Enable;
  logic          Ack;
  logic          RiseTick;
  logic          FallTick;
  logic [CW-1:0] Period;
  logic [CW-1:0] HighTime;
  logic          Valid;
  logic          Overrun;
  logic          Timeout;

  clk_period_meter #(
    .CntWidth  (CW),
    .TimeoutVal(TO)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .ClkIn   (ClkIn),
    .Enable  (Enable),
    .Ack     (Ack),
    .RiseTick(RiseTick),
    .FallTick(FallTick),
    .Period  (Period),
    .HighTime(HighTime),
    .Valid   (Valid),
    .Overrun (Overrun),
    .Timeout (Timeout)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_p[$];
  int exp_h[$];
  bit auto_ack;
  int budget;
  bit locked;
  int prev_p;
  int prev_h;
  int ack_c;
  int cyc;
  int last_rise;
  int n_rise;
  int n_fall;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // Called just after an active edge; samples on the falling edge, returns after the next rising edge
  task automatic step();
    int ep;
    int eh;
    @(negedge Clk);
    if (RiseTick === 1'b1) n_rise++;
    if (FallTick === 1'b1) n_fall++;
    if (Valid === 1'b1 && Ack === 1'b1) begin
      if (exp_p.size() == 0) begin
        chk("sb_underflow", exp_p.size(), 1);
      end else begin
        ep = exp_p.pop_front();
        eh = exp_h.pop_front();
        chk("period", int'(Period), ep);
        chk("hightime", int'(HighTime), eh);
      end
    end
    @(posedge Clk);
    #2;
    cyc++;
  endtask

  task automatic wave(input int p, input int h, input int nper);
    for (int k = 0; k < nper; k++) begin
      for (int c = 0; c < p; c++) begin
        ClkIn = (c < h);
        if (c == 0) begin
          if (locked && budget != 0) begin
            exp_p.push_back(prev_p);
            exp_h.push_back(prev_h);
            if (budget > 0) budget--;
          end
          locked    = 1'b1;
          prev_p    = p;
          prev_h    = h;
          last_rise = cyc;
        end
        Ack = (auto_ack && Valid) || (k == 0 && c == ack_c);
        if (k == 0 && ack_c >= 0 && c == ack_c + 1) begin
          chk("b2b_valid", int'(Valid), 1);
          chk("b2b_overrun", int'(Overrun), 0);
        end
        step();
      end
    end
  endtask

  task automatic idle(input int n);
    ClkIn = 1'b0;
    for (int i = 0; i < n; i++) begin
      Ack = auto_ack && Valid;
      step();
    end
  endtask

  task automatic restart();
    Enable = 1'b0;
    idle(2);
    Enable = 1'b1;
    locked = 1'b0;
    idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Rst      = 1'b0;
    ClkIn    = 1'b0;
    Enable   = 1'b0;
    Ack      = 1'b0;
    auto_ack = 1'b0;
    budget   = -1;
    locked   = 1'b0;
    ack_c    = -1;
    cyc      = 0;
    n_rise   = 0;
    n_fall   = 0;
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_valid", int'(Valid), 0);
    chk("rst_overrun", int'(Overrun), 0);
    chk("rst_timeout", int'(Timeout), 0);
    chk("rst_period", int'(Period), 0);
    chk("rst_hightime", int'(HighTime), 0);
    chk("rst_rise", int'(RiseTick), 0);
    chk("rst_fall", int'(FallTick), 0);
    Rst = 1'b1;
    idle(2);

    // 20-cycle period, 50% duty, acknowledged every time
    Enable   = 1'b1;
    auto_ack = 1'b1;
    idle(1);
    n_rise = 0;
    n_fall = 0;
    wave(20, 10, 5);
    idle(6);
    chk("s1_rise_ticks", n_rise, 5);
    chk("s1_fall_ticks", n_fall, 5);
    chk("s1_sb_empty", exp_p.size(), 0);
    chk("s1_overrun", int'(Overrun), 0);
    chk("s1_timeout", int'(Timeout), 0);

    // 30/7 with Ack withheld: first result held, later ones dropped
    restart();
    auto_ack = 1'b0;
    budget   = 1;
    wave(30, 7, 5);
    chk("s2_valid_held", int'(Valid), 1);
    chk("s2_period_held", int'(Period), 30);
    chk("s2_high_held", int'(HighTime), 7);
    chk("s2_overrun", int'(Overrun), 1);
    budget   = -1;
    auto_ack = 1'b1;
    wave(30, 7, 2);
    chk("s2_sb_empty", exp_p.size(), 0);

    // ClkIn stops low: timeout 200 cycles after the last rising tick
    ClkIn = 1'b0;
    for (int i = 0; i < 300; i++) begin
      Ack = auto_ack && Valid;
      step();
      if (Timeout === 1'b1) break;
    end
    chk("s3_timeout_set", int'(Timeout), 1);
    chk("s3_timeout_delay", cyc - last_rise, TO + 3);
    chk("s3_no_result", int'(Valid), 0);
    locked = 1'b0;
    wave(30, 7, 1);
    chk("s3_timeout_clr", int'(Timeout), 0);
    chk("s3_armed_only", int'(Valid), 0);
    wave(30, 7, 2);
    idle(4);
    chk("s3_sb_empty", exp_p.size(), 0);

    // Ack coinciding with a new candidate while Valid is high
    restart();
    auto_ack = 1'b0;
    wave(24, 12, 1);
    wave(16, 5, 1);
    ack_c = 2;
    wave(40, 9, 1);
    ack_c = -1;
    chk("s4_valid", int'(Valid), 1);
    chk("s4_period", int'(Period), 16);
    chk("s4_high", int'(HighTime), 5);
    chk("s4_overrun", int'(Overrun), 0);
    auto_ack = 1'b1;
    idle(4);
    chk("s4_sb_empty", exp_p.size(), 0);

    // Enable dropped mid-period: held result stays, ticks continue, re-arm needed
    restart();
    auto_ack = 1'b0;
    wave(20, 10, 2);
    Enable = 1'b0;
    idle(3);
    locked = 1'b0;
    chk("s5_valid_held", int'(Valid), 1);
    chk("s5_period_held", int'(Period), 20);
    chk("s5_high_held", int'(HighTime), 10);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("s5_ack_drop", int'(Valid), 0);
    n_rise = 0;
    n_fall = 0;
    wave(20, 10, 1);
    locked = 1'b0;
    chk("s5_ticks_disabled_r", n_rise, 1);
    chk("s5_ticks_disabled_f", n_fall, 1);
    chk("s5_no_result", int'(Valid), 0);
    Enable   = 1'b1;
    auto_ack = 1'b1;
    idle(2);
    wave(20, 10, 1);
    chk("s5_one_edge_only", int'(Valid), 0);
    chk("s5_sb_pending", exp_p.size(), 0);
    wave(20, 10, 1);
    idle(6);
    chk("s5_sb_empty", exp_p.size(), 0);

    // Asynchronous reset mid-measurement with a held result and Overrun set
    restart();
    auto_ack = 1'b0;
    budget   = 1;
    wave(20, 10, 4);
    chk("s6_pre_overrun", int'(Overrun), 1);
    #3;
    Rst = 1'b0;
    #1;
    chk("s6_rst_valid", int'(Valid), 0);
    chk("s6_rst_period", int'(Period), 0);
    chk("s6_rst_high", int'(HighTime), 0);
    chk("s6_rst_overrun", int'(Overrun), 0);
    chk("s6_rst_timeout", int'(Timeout), 0);
    exp_p.delete();
    exp_h.delete();
    budget = -1;
    locked = 1'b0;
    ClkIn  = 1'b0;
    @(posedge Clk);
    #2;
    Rst      = 1'b1;
    auto_ack = 1'b1;
    idle(1);
    wave(20, 10, 3);
    idle(6);
    chk("s6_sb_empty", exp_p.size(), 0);
    chk("s6_overrun", int'(Overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
